// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: captures EX results and the WB/M control groups
// for the MEM stage, with synchronous reset, stall (hold) and flush (bubble).
module ex_mem_latch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        ctlwb_in,
  input  logic [1:0]        ctlm_in,
  input  logic [DATA_W-1:0] adder_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [REG_W-1:0]  muxout_in,
  output logic [1:0]        ctlwb_out,
  output logic [1:0]        ctlm_out,
  output logic [DATA_W-1:0] adder_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [REG_W-1:0]  muxout_out
);

  // Pipeline slot: reset and flush both load an all-zero bubble, stall holds.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ctlwb_out      <= 2'b00;
      ctlm_out       <= 2'b00;
      adder_out      <= '0;
      alu_result_out <= '0;
      rdata2_out     <= '0;
      muxout_out     <= '0;
    end else if (!stall) begin
      ctlwb_out      <= ctlwb_in;
      ctlm_out       <= ctlm_in;
      adder_out      <= adder_in;
      alu_result_out <= alu_result_in;
      rdata2_out     <= rdata2_in;
      muxout_out     <= muxout_in;
    end
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// Self-checking bench for ex_mem_latch: expected slot contents are queued
// as each edge's stimulus is driven and compared one cycle later.
module tb_ex_mem_latch;

  typedef struct packed {
    logic [1:0]  ctlwb;
    logic [1:0]  ctlm;
    logic [31:0] adder;
    logic [31:0] alu;
    logic [31:0] rdata2;
    logic [4:0]  mux;
  } vec_t;

  localparam vec_t S2 = '{2'b01, 2'b10, 32'h12345678, 32'hABCDEF01, 32'h0F0F0F0F, 5'h1A};
  localparam vec_t S3 = '{2'b11, 2'b00, 32'h87654321, 32'hFEDCBA98, 32'h00FF00FF, 5'h0F};

  logic clk = 1'b0;
  logic rst, stall, flush;
  vec_t din;
  vec_t model;
  vec_t got;
  vec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [1:0]  ctlwb_out, ctlm_out;
  logic [31:0] adder_out, alu_result_out, rdata2_out;
  logic [4:0]  muxout_out;

  always #5 clk = ~clk;

  assign got = {ctlwb_out, ctlm_out, adder_out, alu_result_out, rdata2_out, muxout_out};

  ex_mem_latch #(.DATA_W(32), .REG_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .ctlwb_in       (din.ctlwb),
    .ctlm_in        (din.ctlm),
    .adder_in       (din.adder),
    .alu_result_in  (din.alu),
    .rdata2_in      (din.rdata2),
    .muxout_in      (din.mux),
    .ctlwb_out      (ctlwb_out),
    .ctlm_out       (ctlm_out),
    .adder_out      (adder_out),
    .alu_result_out (alu_result_out),
    .rdata2_out     (rdata2_out),
    .muxout_out     (muxout_out)
  );

  function automatic vec_t rand_vec();
    vec_t v;
    v.ctlwb  = 2'($urandom);
    v.ctlm   = 2'($urandom);
    v.adder  = $urandom | 32'h1;
    v.alu    = $urandom | 32'h2;
    v.rdata2 = $urandom | 32'h4;
    v.mux    = 5'($urandom);
    return v;
  endfunction

  // Drive one edge's inputs mid-cycle and queue the slot value expected after it.
  task automatic drive(input logic r, input logic f, input logic s, input vec_t v);
    @(negedge clk);
    rst = r; flush = f; stall = s; din = v;
    if (r || f)  model = '0;
    else if (!s) model = v;
    q.push_back(model);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t exp;
    drive(1'b1, 1'b0, 1'b0, rand_vec());
    tick();
    exp = q.pop_front();
    vectors++;
    if (got !== exp || got !== vec_t'(0)) begin
      miscompares++;
      $display("FAIL reset_clear: got=%h expected=%h", got, exp);
    end
    drive(1'b0, 1'b0, 1'b0, S3);
    tick();
    exp = q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_release_load: got=%h expected=%h", got, exp);
    end
  endtask

  task automatic test_basic();
    vec_t exp;
    drive(1'b0, 1'b0, 1'b0, S2);
    tick();
    exp = q.pop_front();
    vectors++;
    if (got !== exp || got !== S2) begin
      miscompares++;
      $display("FAIL basic_capture: got=%h expected=%h", got, S2);
    end
  endtask

  task automatic test_back_to_back();
    vec_t exp;
    drive(1'b0, 1'b0, 1'b0, S3);
    #1;
    vectors++;
    if (got !== S2) begin
      miscompares++;
      $display("FAIL b2b_before_edge: got=%h expected=%h", got, S2);
    end
    tick();
    exp = q.pop_front();
    vectors++;
    if (got !== exp || got !== S3) begin
      miscompares++;
      $display("FAIL b2b_after_edge: got=%h expected=%h", got, S3);
    end
  endtask

  task automatic test_stall();
    vec_t exp;
    vec_t v;
    drive(1'b0, 1'b0, 1'b0, S2);
    tick();
    void'(q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, rand_vec());
      tick();
      exp = q.pop_front();
      vectors++;
      if (got !== exp || got !== S2) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got=%h expected=%h", i, got, S2);
      end
    end
    v = rand_vec();
    drive(1'b0, 1'b0, 1'b0, v);
    tick();
    exp = q.pop_front();
    vectors++;
    if (got !== exp || got !== v) begin
      miscompares++;
      $display("FAIL stall_release: got=%h expected=%h", got, v);
    end
  endtask

  task automatic test_flush();
    vec_t exp;
    vec_t v;
    for (int mode = 0; mode < 2; mode++) begin
      drive(1'b0, 1'b0, 1'b0, rand_vec());
      tick();
      void'(q.pop_front());
      drive(1'b0, 1'b1, 1'(mode), rand_vec());
      tick();
      exp = q.pop_front();
      vectors++;
      if (got !== exp || got !== vec_t'(0)) begin
        miscompares++;
        $display("FAIL flush_bubble stall=%0d: got=%h expected=%h", mode, got, exp);
      end
      v = rand_vec();
      drive(1'b0, 1'b0, 1'b0, v);
      tick();
      exp = q.pop_front();
      vectors++;
      if (got !== exp || got !== v) begin
        miscompares++;
        $display("FAIL flush_resume stall=%0d: got=%h expected=%h", mode, got, v);
      end
    end
  endtask

  task automatic test_reset_priority();
    vec_t exp;
    vec_t v;
    drive(1'b0, 1'b0, 1'b0, S3);
    tick();
    void'(q.pop_front());
    drive(1'b1, 1'b0, 1'b1, rand_vec());
    tick();
    exp = q.pop_front();
    vectors++;
    if (got !== exp || got !== vec_t'(0)) begin
      miscompares++;
      $display("FAIL reset_over_stall: got=%h expected=%h", got, exp);
    end
    v = rand_vec();
    drive(1'b0, 1'b0, 1'b0, v);
    tick();
    exp = q.pop_front();
    vectors++;
    if (got !== exp || got !== v) begin
      miscompares++;
      $display("FAIL reset_resume: got=%h expected=%h", got, v);
    end
  endtask

  task automatic test_random_mix();
    vec_t exp;
    logic r, f, s;
    for (int i = 0; i < 60; i++) begin
      r = ($urandom_range(0, 15) == 0);
      f = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      drive(r, f, s, rand_vec());
      tick();
      exp = q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_mix[%0d] rst=%0b flush=%0b stall=%0b: got=%h expected=%h",
                 i, r, f, s, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; din = '0; model = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_basic();
    test_stall();
    test_flush();
    test_reset_priority();
    test_random_mix();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
EX/MEM pipeline register of the 5-stage MIPS pipeline, sitting between the EX stage (ALU, branch-target adder, write-register mux) and the MEM stage. It captures the EX results and the remaining WB/M control fields on each rising clock edge and holds them stable for MEM for one full cycle. It adds synchronous reset, stall (hold) and flush (bubble insertion) for hazard control.

Parameters:
DATA_W  32  width of adder, ALU result and rdata2 datapaths
REG_W   5   width of destination register index

Ports:
clk            input   1       rising-edge clock
rst            input   1       synchronous active-high reset
stall          input   1       1 = hold all outputs (ignore *_in)
flush          input   1       1 = load a bubble (all outputs zero)
ctlwb_in       input   2       WB control group from ID/EX (opaque, not decoded)
ctlm_in        input   2       M control group from ID/EX (opaque, not decoded)
adder_in       input   DATA_W  branch-target adder result
alu_result_in  input   DATA_W  ALU result / memory address
rdata2_in      input   DATA_W  register-file read data 2 (store data)
muxout_in      input   REG_W   selected destination register index
ctlwb_out      output  2       registered ctlwb_in
ctlm_out       output  2       registered ctlm_in
adder_out      output  DATA_W  registered adder_in
alu_result_out output  DATA_W  registered alu_result_in
rdata2_out     output  DATA_W  registered rdata2_in
muxout_out     output  REG_W   registered muxout_in

Behaviour:
- Single clock domain: clk, rising edge only. Reset is synchronous and active-high, sampled only on clk rising edge.
- All outputs are driven directly from flops. No combinational path from any input to any output.
- Per-edge priority: rst > flush > stall > normal load.
- rst=1: every output becomes 0 (ctlwb_out=2'b00, ctlm_out=2'b00, adder_out, alu_result_out, rdata2_out = 0, muxout_out=0).
- flush=1 (rst=0): every output cleared to 0, the same as reset. The zeroed control fields make the slot a no-op in MEM/WB.
- stall=1 (rst=0, flush=0): all outputs keep their current values.
- Normal load (rst=0, flush=0, stall=0): each *_out takes its *_in value from the edge. Latency is exactly 1 cycle. Throughput is one set of values per cycle.
- Inputs changing between edges have no effect on the outputs until the next rising edge.
- Power-up before the first reset is undefined. The bench must assert rst for at least 1 cycle first.
- Reset asserted mid-operation: outputs are zero after the edge where rst=1, regardless of stall/flush. Normal loading resumes on the first edge after rst deasserts.
- stall and flush both high: flush wins and outputs go to 0.
- Control bits pass through bit-exact and are never interpreted. No arithmetic, width conversion or sign extension is performed. Widths of inputs and outputs match exactly.

Test Plan:
1. Reset: drive arbitrary inputs with rst=1 for 1 edge -> all outputs 0. Deassert rst -> next edge loads inputs.
2. Basic capture: rst=0, ctlwb_in=01, ctlm_in=10, adder_in=32'h12345678, alu_result_in=32'hABCDEF01, rdata2_in=32'h0F0F0F0F, muxout_in=5'h1A, edge -> outputs equal those values exactly.
3. Back-to-back update: next cycle drive ctlwb_in=11, ctlm_in=00, adder_in=32'h87654321, alu_result_in=32'hFEDCBA98, rdata2_in=32'h00FF00FF, muxout_in=5'h0F -> outputs hold the scenario-2 values until the edge, then switch to the new values. Check just before and just after the edge.
4. Stall: after scenario 2, set stall=1 and change all inputs for 3 edges -> outputs stay 01/10/12345678/ABCDEF01/0F0F0F0F/1A. Release stall -> next edge loads the current inputs.
5. Flush, and flush over stall: with valid data loaded, assert flush=1 (also with stall=1) -> all outputs 0 after the edge. Deassert both -> the next edge loads the inputs.
6. Reset priority mid-stream: rst=1 together with stall=1 and flush=0 while outputs hold nonzero data -> outputs 0 after the edge. Deassert rst -> capture resumes after 1 cycle.
